// File: rtl/keypad_matrix_scanner.sv
// ============================================================================
// Module   : keypad_matrix_scanner
// Brief    : ROWSxCOLS key-matrix scanner with settle time, multi-frame
//            debounce, ghost rejection and press/release event pulses.
//            Optional auto-repeat enabled by defining KEYPAD_REPEAT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_matrix_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE_CYC = 4,
  parameter int DEB_FRAMES = 3,
`ifdef KEYPAD_REPEAT_EN
  parameter int REPEAT_DLY = 32,
  parameter int REPEAT_PER = 8,
`endif
  parameter int KEY_W      = $clog2(ROWS*COLS+1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ROWS-1:0]  row_out,
  input  logic [COLS-1:0]  col_in,
  output logic [KEY_W-1:0] key_value,
  output logic             key_down,
  output logic             key_valid,
  output logic             key_release
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int SET_W = $clog2(SETTLE_CYC);
  localparam logic [KEY_W-1:0] NO_KEY = KEY_W'(ROWS*COLS);

  logic [ROWS-1:0]  row_out_q, row_out_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [KEY_W-1:0] acc_code_q, acc_code_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [3:0]       deb_q, deb_d;
  logic [KEY_W-1:0] key_value_q, key_value_d;
  logic             key_down_q, key_down_d;
  logic             key_valid_q, key_valid_d;
  logic             key_release_q, key_release_d;
`ifdef KEYPAD_REPEAT_EN
  logic [15:0]      rep_q, rep_d;
  logic             rep_first_q, rep_first_d;
`endif

  logic [1:0]       col_hits;
  logic [COL_W-1:0] col_idx;
  logic             sample;
  logic             wrap;
  logic [KEY_W-1:0] row_code;
  logic [1:0]       merged_cnt;
  logic [KEY_W-1:0] merged_code;
  logic [KEY_W-1:0] frame_res;

  // Column hit count saturates at 2: anything beyond one hit is a multi-key frame.
  always_comb begin
    col_hits = 2'd0;
    col_idx  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_in[c]) begin
        col_idx = COL_W'(c);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
  end

  always_comb begin
    sample   = (settle_q == SET_W'(SETTLE_CYC-1));
    wrap     = sample && (row_idx_q == ROW_W'(ROWS-1));
    row_code = KEY_W'(int'(row_idx_q) * COLS + int'(col_idx));

    if (acc_cnt_q == 2'd0)      merged_cnt = col_hits;
    else if (col_hits == 2'd0)  merged_cnt = acc_cnt_q;
    else                        merged_cnt = 2'd2;

    merged_code = (acc_cnt_q == 2'd0 && col_hits == 2'd1) ? row_code : acc_code_q;
    frame_res   = (merged_cnt == 2'd1) ? merged_code : NO_KEY;
  end

  always_comb begin
    row_out_d     = row_out_q;
    row_idx_d     = row_idx_q;
    settle_d      = settle_q + SET_W'(1);
    acc_cnt_d     = acc_cnt_q;
    acc_code_d    = acc_code_q;
    cand_d        = cand_q;
    deb_d         = deb_q;
    key_value_d   = key_value_q;
    key_down_d    = key_down_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d         = rep_q;
    rep_first_d   = rep_first_q;
`endif

    if (sample) begin
      settle_d  = '0;
      row_out_d = {row_out_q[ROWS-2:0], row_out_q[ROWS-1]};
      row_idx_d = wrap ? '0 : row_idx_q + ROW_W'(1);
      if (wrap) begin
        acc_cnt_d  = 2'd0;
        acc_code_d = NO_KEY;
      end else begin
        acc_cnt_d  = merged_cnt;
        acc_code_d = merged_code;
      end
    end

    if (wrap) begin
      if (frame_res == cand_q) begin
        if (deb_q != 4'd15) deb_d = deb_q + 4'd1;
      end else begin
        cand_d = frame_res;
        deb_d  = 4'd1;
      end
`ifdef KEYPAD_REPEAT_EN
      // Repeat timer runs only while the held key keeps being seen unchanged.
      if (key_down_q && frame_res == key_value_q) begin
        rep_d = rep_q + 16'd1;
        if (rep_q + 16'd1 == (rep_first_q ? 16'(REPEAT_DLY) : 16'(REPEAT_PER))) begin
          key_valid_d = 1'b1;
          rep_d       = 16'd0;
          rep_first_d = 1'b0;
        end
      end else begin
        rep_d       = 16'd0;
        rep_first_d = 1'b1;
      end
`endif
    end

    // Acceptance lands one cycle after the deciding frame edge, so it never meets a wrap.
    if (deb_q >= 4'(DEB_FRAMES) && cand_q != key_value_q) begin
      key_value_d = cand_q;
      if (cand_q != NO_KEY) begin
        key_down_d  = 1'b1;
        key_valid_d = 1'b1;
      end else begin
        key_down_d    = 1'b0;
        key_release_d = 1'b1;
      end
`ifdef KEYPAD_REPEAT_EN
      rep_d       = 16'd0;
      rep_first_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_out_q     <= ROWS'(1);
      row_idx_q     <= '0;
      settle_q      <= '0;
      acc_cnt_q     <= 2'd0;
      acc_code_q    <= NO_KEY;
      cand_q        <= NO_KEY;
      deb_q         <= 4'd0;
      key_value_q   <= NO_KEY;
      key_down_q    <= 1'b0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q         <= 16'd0;
      rep_first_q   <= 1'b1;
`endif
    end else begin
      row_out_q     <= row_out_d;
      row_idx_q     <= row_idx_d;
      settle_q      <= settle_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_code_q    <= acc_code_d;
      cand_q        <= cand_d;
      deb_q         <= deb_d;
      key_value_q   <= key_value_d;
      key_down_q    <= key_down_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q         <= rep_d;
      rep_first_q   <= rep_first_d;
`endif
    end
  end

  assign row_out     = row_out_q;
  assign key_value   = key_value_q;
  assign key_down    = key_down_q;
  assign key_valid   = key_valid_q;
  assign key_release = key_release_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
// ============================================================================
// Module   : tb_keypad_matrix_scanner
// Brief    : Scoreboard bench for keypad_matrix_scanner (4x4, settle 4, debounce 3).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_matrix_scanner;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int FRAME      = 16;
  localparam int DEB_FRAMES = 3;
  localparam int NO_KEY     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [4:0]  key_value;
  logic        key_down;
  logic        key_valid;
  logic        key_release;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit rel;
    int code;
    int lo;
    int hi;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  keypad_matrix_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .row_out     (row_out),
    .col_in      (col_in),
    .key_value   (key_value),
    .key_down    (key_down),
    .key_valid   (key_valid),
    .key_release (key_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Passive key matrix: a pressed key connects its row strobe to its column.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && row_out[r]) col_in[c] = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_evt(input bit rel, input int code, input int start);
    exp_t e;
    e.rel  = rel;
    e.code = code;
    e.lo   = start + DEB_FRAMES * FRAME;
    e.hi   = start + (DEB_FRAMES + 1) * FRAME;
    exp_q.push_back(e);
  endtask

  task automatic sync_frame();
    logic [3:0] prev;
    bit seen;
    seen = 1'b0;
    prev = row_out;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (row_out == 4'b0001 && prev != 4'b0001) seen = 1'b1;
      prev = row_out;
    end
    if (!seen) begin
      $display("FAIL frame_sync: row_out=%b, required a row 0 strobe", row_out);
      $fatal(1, "scan stalled");
    end
  endtask

  // Monitor: every event pulse is matched against the oldest expected event.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid || key_release) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: valid=%b release=%b key_value=%0d, required no event",
                   key_valid, key_release, key_value);
        end else begin
          mon_e = exp_q.pop_front();
          chk("evt_kind", {30'd0, key_valid, key_release}, mon_e.rel ? 32'd1 : 32'd2);
          chk("evt_key_value", 32'(key_value), 32'(mon_e.code));
          chk("evt_key_down", 32'(key_down), mon_e.rel ? 32'd0 : 32'd1);
          checks++;
          if (cyc < mon_e.lo || cyc > mon_e.hi) begin
            errors++;
            $display("FAIL evt_timing: event at cycle %0d, required %0d..%0d",
                     cyc, mon_e.lo, mon_e.hi);
          end
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
        checks++;
        errors++;
        $display("FAIL evt_timeout: no event by cycle %0d, required code %0d rel=%0d",
                 cyc, exp_q[0].code, exp_q[0].rel);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    keys = '0;
    repeat (3) @(negedge clk);
    chk("reset_row_out", 32'(row_out), 32'd1);
    chk("reset_key_value", 32'(key_value), NO_KEY);
    chk("reset_key_down", 32'(key_down), 32'd0);
    chk("reset_pulses", {30'd0, key_valid, key_release}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 200; k++) begin
      chk("idle_row_out", 32'(row_out), 32'd1 << ((k / 4) % 4));
      @(negedge clk);
    end
    chk("idle_key_value", 32'(key_value), NO_KEY);
    chk("idle_key_down", 32'(key_down), 32'd0);

    // Single press of key 9 (row 2, col 1)
    sync_frame();
    keys = 16'(1 << 9);
    expect_evt(1'b0, 9, cyc);
    repeat (5) sync_frame();
    chk("press9_key_value", 32'(key_value), 32'd9);
    chk("press9_key_down", 32'(key_down), 32'd1);

    // Direct switch to another key: valid pulse only, no release
    keys = 16'(1 << 6);
    expect_evt(1'b0, 6, cyc);
    repeat (5) sync_frame();
    chk("switch6_key_value", 32'(key_value), 32'd6);

    keys = '0;
    expect_evt(1'b1, NO_KEY, cyc);
    repeat (5) sync_frame();
    chk("release_key_value", 32'(key_value), NO_KEY);
    chk("release_key_down", 32'(key_down), 32'd0);

    // Corner codes: last key, then first key
    keys = 16'(1 << 15);
    expect_evt(1'b0, 15, cyc);
    repeat (5) sync_frame();
    keys = 16'd1;
    expect_evt(1'b0, 0, cyc);
    repeat (5) sync_frame();
    keys = '0;
    expect_evt(1'b1, NO_KEY, cyc);
    repeat (5) sync_frame();

    // Bounce: key present only in alternate frames
    for (int f = 0; f < 10; f++) begin
      keys = (f % 2 == 0) ? 16'(1 << 9) : 16'd0;
      sync_frame();
    end
    keys = '0;
    repeat (4) sync_frame();
    chk("bounce_key_value", 32'(key_value), NO_KEY);

    // Ghost: two keys in different rows and columns
    keys = 16'((1 << 5) | (1 << 10));
    repeat (6) sync_frame();
    chk("ghost_key_value", 32'(key_value), NO_KEY);
    chk("ghost_key_down", 32'(key_down), 32'd0);
    keys = '0;
    repeat (4) sync_frame();

    // Reset in the middle of debouncing a press
    sync_frame();
    keys = 16'(1 << 9);
    repeat (2) sync_frame();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_row_out", 32'(row_out), 32'd1);
    chk("midrst_key_value", 32'(key_value), NO_KEY);
    chk("midrst_pulses", {30'd0, key_valid, key_release}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_evt(1'b0, 9, cyc);
    repeat (5) sync_frame();
    chk("midrst_press_key_value", 32'(key_value), 32'd9);
    keys = '0;
    expect_evt(1'b1, NO_KEY, cyc);
    repeat (5) sync_frame();

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
